store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 47 ++++
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus: core store handshake, drain control, load forwarding
// path and the memory read/write ports, bundled as one interface.
// The slave side is the buffer; the master side is the core plus memory.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_address;
  logic [31:0] st_data;
  logic        drain_en;
  logic [31:0] ld_address;
  logic [31:0] ld_data;
  logic [31:0] mem_read_address_1;
  logic [31:0] mem_read_data_1;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;

  modport master (
    output st_valid,
    output st_address,
    output st_data,
    output drain_en,
    output ld_address,
    output mem_read_data_1,
    input  st_ready,
    input  ld_data,
    input  mem_read_address_1,
    input  mem_write_address,
    input  mem_write_data,
    input  mem_write_enable
  );

  modport slave (
    input  st_valid,
    input  st_address,
    input  st_data,
    input  drain_en,
    input  ld_address,
    input  mem_read_data_1,
    output st_ready,
    output ld_data,
    output mem_read_address_1,
    output mem_write_address,
    output mem_write_data,
    output mem_write_enable
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: a FIFO of {address, data} entries that accepts
// stores from the core, retires the head entry to memory one per cycle when
// drain_en allows, and forwards the youngest matching entry to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Entry storage; contents are meaningful only where the valid bit is set.
  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] match_vec;

  logic             st_ready_int;
  logic             empty_int;
  logic             enq;
  logic             deq;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] fwd_idx;

  // Ready and empty come only from registered occupancy, so st_ready never
  // sees a same-cycle retire: a full buffer reopens the cycle after a drain.
  assign st_ready_int = (count_reg != CNT_W'(DEPTH));
  assign empty_int    = (count_reg == '0);
  assign enq          = bus.st_valid && st_ready_int;
  assign deq          = bus.drain_en && !empty_int;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (enq) begin
      tail_next = tail_reg + 1'b1;
    end
    if (deq) begin
      head_next = head_reg + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; reset discards every pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Capture the accepted store into the tail slot; storage needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_reg] <= bus.st_address;
      data_mem[tail_reg] <= bus.st_data;
    end
  end

  // Per-entry valid bit and load-address comparator.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic entry_valid_reg;

      // Set on enqueue into this slot, cleared when this slot retires.
      // Enqueue and retire cannot target the same slot in one cycle: that
      // would require the buffer to be both empty and full.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_valid_reg <= 1'b0;
        end else if (enq && (tail_reg == PTR_W'(gi))) begin
          entry_valid_reg <= 1'b1;
        end else if (deq && (head_reg == PTR_W'(gi))) begin
          entry_valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi] = entry_valid_reg;
      // The head entry retiring this cycle is still valid here, so it keeps
      // forwarding until memory has actually been written.
      assign match_vec[gi] = entry_valid_reg && (addr_mem[gi] == bus.ld_address);
    end
  endgenerate

  // Walk entries oldest to youngest from head; the last hit wins, which is
  // the youngest matching store. A store enqueued this cycle is not valid
  // yet, so it cannot forward until the next cycle.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (match_vec[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  assign bus.st_ready           = st_ready_int;
  assign bus.mem_read_address_1 = bus.ld_address;
  assign bus.ld_data            = fwd_hit ? fwd_data : bus.mem_read_data_1;
  assign bus.mem_write_address  = addr_mem[head_reg];
  assign bus.mem_write_data     = data_mem[head_reg];
  assign bus.mem_write_enable   = deq;

  assign count = count_reg;
  assign empty = empty_int;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4) with a small word memory model
// that logs every write so ordering and duplicates can be checked.
module tb_store_buffer;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  logic       empty;

  store_buffer_if bus();

  store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words indexed by address[7:0]; unwritten words read a
  // recognisable background pattern.
  bit [31:0] mem_q     [256];
  bit        written_q [256];
  bit [31:0] wr_addr_log [128];
  bit [31:0] wr_data_log [128];
  int        wr_count;

  function automatic logic [31:0] bg(input logic [31:0] a);
    return {24'hB0B0B0, a[7:0]};
  endfunction

  assign bus.mem_read_data_1 = written_q[bus.mem_read_address_1[7:0]]
                             ? mem_q[bus.mem_read_address_1[7:0]]
                             : bg(bus.mem_read_address_1);

  // Memory captures writes on the rising edge and logs them in order.
  always @(posedge clk) begin
    if (bus.mem_write_enable === 1'b1) begin
      mem_q[bus.mem_write_address[7:0]]     <= bus.mem_write_data;
      written_q[bus.mem_write_address[7:0]] <= 1'b1;
      wr_addr_log[wr_count[6:0]]            <= bus.mem_write_address;
      wr_data_log[wr_count[6:0]]            <= bus.mem_write_data;
      wr_count                              <= wr_count + 1;
    end
  end

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic v, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid   = v;
    bus.st_address = a;
    bus.st_data    = d;
  endtask

  // Watchdog: the sequence is short, so this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    store(1'b0, 32'd0, 32'd0);
    bus.drain_en   = 1'b0;
    bus.ld_address = 32'd0;

    // Reset state
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(bus.st_ready), 32'd1);
    check("rst_mwe", 32'(bus.mem_write_enable), 32'd0);
    check("rst_ld_data", bus.ld_data, 32'hB0B0B000);
    check("rst_rd_addr", bus.mem_read_address_1, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full with drain disabled
    for (int i = 0; i < 4; i++) begin
      store(1'b1, 32'd10 + 32'(i), 32'h10A + 32'(i));
      #1;
      check("fill_ready", 32'(bus.st_ready), 32'd1);
      check("fill_count", 32'(count), 32'(i));
      tick();
    end
    store(1'b1, 32'd99, 32'h999);
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.st_ready), 32'd0);
    check("full_mwe", 32'(bus.mem_write_enable), 32'd0);
    tick();
    check("full_ignored_count", 32'(count), 32'd4);

    // Drain in order, one write per cycle
    store(1'b0, 32'd0, 32'd0);
    bus.drain_en = 1'b1;
    w0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_mwe", 32'(bus.mem_write_enable), 32'd1);
      check("drain_addr", bus.mem_write_address, 32'd10 + 32'(i));
      check("drain_data", bus.mem_write_data, 32'h10A + 32'(i));
      tick();
    end
    #1;
    check("drained_empty", 32'(empty), 32'd1);
    check("empty_mwe_with_drain", 32'(bus.mem_write_enable), 32'd0);
    check("drain_wr_count", 32'(wr_count - w0), 32'd4);
    check("drain_last_addr", wr_addr_log[w0 + 3], 32'd13);
    bus.ld_address = 32'd12;
    #1;
    check("mem_readback_12", bus.ld_data, 32'h10C);
    bus.drain_en = 1'b0;

    // Youngest match forwards; a store in flight does not forward yet
    store(1'b1, 32'd20, 32'hAAAA);
    bus.ld_address = 32'd20;
    #1;
    check("no_fwd_same_cycle", bus.ld_data, 32'hB0B0B014);
    tick();
    store(1'b1, 32'd20, 32'hBBBB);
    #1;
    check("fwd_first_store", bus.ld_data, 32'hAAAA);
    tick();
    store(1'b0, 32'd0, 32'd0);
    #1;
    check("fwd_youngest", bus.ld_data, 32'hBBBB);
    bus.ld_address = 32'd21;
    #1;
    check("no_match_mem", bus.ld_data, 32'hB0B0B015);
    bus.ld_address = 32'd20;
    bus.drain_en   = 1'b1;
    #1;
    check("fwd_while_drain_old", bus.ld_data, 32'hBBBB);
    check("drain_old_data", bus.mem_write_data, 32'hAAAA);
    tick();
    check("fwd_retiring_head", bus.ld_data, 32'hBBBB);
    check("drain_new_data", bus.mem_write_data, 32'hBBBB);
    tick();
    bus.drain_en = 1'b0;
    #1;
    check("yw_empty", 32'(empty), 32'd1);
    check("yw_mem_final", bus.ld_data, 32'hBBBB);

    // Forward while retiring the single entry
    store(1'b1, 32'd30, 32'h1234);
    bus.ld_address = 32'd30;
    tick();
    store(1'b0, 32'd0, 32'd0);
    bus.drain_en = 1'b1;
    #1;
    check("retire_fwd_data", bus.ld_data, 32'h1234);
    check("retire_fwd_mwe", 32'(bus.mem_write_enable), 32'd1);
    tick();
    bus.drain_en = 1'b0;
    #1;
    check("retire_mem_data", bus.ld_data, 32'h1234);
    check("retire_empty", 32'(empty), 32'd1);

    // Simultaneous enqueue and retire at count=2
    store(1'b1, 32'd40, 32'h40);
    tick();
    store(1'b1, 32'd41, 32'h41);
    tick();
    store(1'b1, 32'd42, 32'h42);
    bus.drain_en = 1'b1;
    #1;
    check("sim_wr_addr_40", bus.mem_write_address, 32'd40);
    tick();
    store(1'b1, 32'd43, 32'h43);
    #1;
    check("sim_count_a", 32'(count), 32'd2);
    check("sim_wr_addr_41", bus.mem_write_address, 32'd41);
    tick();
    store(1'b0, 32'd0, 32'd0);
    #1;
    check("sim_count_b", 32'(count), 32'd2);
    check("sim_wr_addr_42", bus.mem_write_address, 32'd42);
    tick();
    check("sim_wr_addr_43", bus.mem_write_address, 32'd43);
    tick();
    bus.drain_en = 1'b0;
    #1;
    check("sim_empty", 32'(empty), 32'd1);

    // Full with retire and store in the same cycle: ready stays low
    for (int i = 0; i < 4; i++) begin
      store(1'b1, 32'd50 + 32'(i), 32'h50 + 32'(i));
      tick();
    end
    store(1'b1, 32'd54, 32'h54);
    bus.drain_en = 1'b1;
    #1;
    check("full_drain_ready", 32'(bus.st_ready), 32'd0);
    check("full_drain_mwe", 32'(bus.mem_write_enable), 32'd1);
    check("full_drain_addr", bus.mem_write_address, 32'd50);
    tick();
    store(1'b0, 32'd0, 32'd0);
    #1;
    check("full_drain_count", 32'(count), 32'd3);
    check("full_drain_ready_next", 32'(bus.st_ready), 32'd1);
    check("full_drain_addr_51", bus.mem_write_address, 32'd51);
    tick();
    check("full_drain_addr_52", bus.mem_write_address, 32'd52);
    tick();
    check("full_drain_addr_53", bus.mem_write_address, 32'd53);
    tick();
    bus.drain_en = 1'b0;
    bus.ld_address = 32'd54;
    #1;
    check("full_drain_empty", 32'(empty), 32'd1);
    check("rejected_never_written", bus.ld_data, 32'hB0B0B036);

    // Asynchronous reset mid-operation discards pending stores
    for (int i = 0; i < 3; i++) begin
      store(1'b1, 32'd60 + 32'(i), 32'h60 + 32'(i));
      tick();
    end
    store(1'b0, 32'd0, 32'd0);
    #1;
    check("pre_reset_count", 32'(count), 32'd3);
    w0 = wr_count;
    #2;
    bus.drain_en = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_mwe", 32'(bus.mem_write_enable), 32'd0);
    check("async_rst_ready", 32'(bus.st_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    bus.ld_address = 32'd60;
    #1;
    check("rst_no_writes", 32'(wr_count - w0), 32'd0);
    check("rst_pending_discarded", bus.ld_data, 32'hB0B0B03C);
    bus.drain_en = 1'b0;

    // Wrap-around: 10 enqueue/retire pairs
    w0 = wr_count;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(1'b1, 32'd70 + 32'(i), 32'h7000 + 32'(i));
      #1;
      if (i > 0) begin
        check("wrap_count", 32'(count), 32'd1);
        check("wrap_addr", bus.mem_write_address, 32'd69 + 32'(i));
      end else begin
        check("wrap_first_mwe", 32'(bus.mem_write_enable), 32'd0);
      end
      tick();
    end
    store(1'b0, 32'd0, 32'd0);
    #1;
    check("wrap_last_addr", bus.mem_write_address, 32'd79);
    tick();
    bus.drain_en = 1'b0;
    #1;
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_wr_count", 32'(wr_count - w0), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("wrap_log_addr", wr_addr_log[w0 + i], 32'd70 + 32'(i));
      check("wrap_log_data", wr_data_log[w0 + i], 32'h7000 + 32'(i));
    end
    bus.ld_address = 32'd75;
    #1;
    check("wrap_mem_75", bus.ld_data, 32'h7005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
